// File: rtl/cu_pkg.sv
// Shared types and default sizing for the attention compute-unit sequencer.
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q_K  = 3'd1,
    EXP  = 3'd2,
    S_V  = 3'd3,
    DONE = 3'd4
  } cu_state_e;

  localparam int unsigned QK_LEN_DEF     = 65;
  localparam int unsigned SV_LEN_DEF     = 65;
  localparam int unsigned V_REQ_LEAD_DEF = 1;
  localparam int unsigned TILE_W_DEF     = 8;

  // Beat counter width wide enough for the longer of the two phases.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cu_seq_if.sv
// Scheduler/PE-side bundle of the cu_seq sequencer; perf ports exist only with CU_SEQ_PERF_CNT_EN.
interface cu_seq_if #(parameter int unsigned TILE_W = cu_pkg::TILE_W_DEF);

  logic              i_start;
  logic [TILE_W-1:0] i_num_tiles;
  logic              i_abort;
  logic              i_qk_valid;
  logic              i_v_valid;
  logic              i_exp_valid;
  logic              o_qk_ready;
  logic              o_v_ready;
  logic              o_accu_en;
  logic              o_qk_part_last;
  logic              o_mult_en;
  logic              o_mult_clear;
  logic              o_reduction_en;
  logic              o_v_data_request;
  logic [TILE_W-1:0] o_tile_idx;
  logic              o_busy;
  logic              o_done;
`ifdef CU_SEQ_PERF_CNT_EN
  logic [31:0]       o_stall_cycles;
  logic [31:0]       o_exp_wait_cycles;
`endif

  modport master (
    output i_start, i_num_tiles, i_abort, i_qk_valid, i_v_valid, i_exp_valid,
    input  o_qk_ready, o_v_ready, o_accu_en, o_qk_part_last, o_mult_en, o_mult_clear,
           o_reduction_en, o_v_data_request, o_tile_idx, o_busy, o_done
`ifdef CU_SEQ_PERF_CNT_EN
    , input o_stall_cycles, o_exp_wait_cycles
`endif
  );

  modport slave (
    input  i_start, i_num_tiles, i_abort, i_qk_valid, i_v_valid, i_exp_valid,
    output o_qk_ready, o_v_ready, o_accu_en, o_qk_part_last, o_mult_en, o_mult_clear,
           o_reduction_en, o_v_data_request, o_tile_idx, o_busy, o_done
`ifdef CU_SEQ_PERF_CNT_EN
    , output o_stall_cycles, o_exp_wait_cycles
`endif
  );

endinterface

// File: rtl/cu_beat_cnt.sv
// Stall-aware beat counter shared by the Q_K and S_V phases; wraps to 0 on the last beat.
module cu_beat_cnt #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last_val,
  input  logic [CNT_W-1:0] lead_val,
  output logic             at_last_c,
  output logic             last_c,
  output logic             lead_c
);

  logic [CNT_W-1:0] cnt;

  assign at_last_c = (cnt == last_val);
  assign last_c    = at_last_c & en;
  assign lead_c    = (cnt == lead_val) & en;

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (last_c) cnt <= '0;
    else if (en)     cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/cu_seq.sv
// Multi-tile Q.K^T -> exp -> S.V sequencer driving pe_array / fan_ctrl / V-fetch.
// Optional performance counters are enabled with CU_SEQ_PERF_CNT_EN.
module cu_seq
  import cu_pkg::*;
#(
  parameter int unsigned QK_LEN     = QK_LEN_DEF,
  parameter int unsigned SV_LEN     = SV_LEN_DEF,
  parameter int unsigned V_REQ_LEAD = V_REQ_LEAD_DEF,
  parameter int unsigned TILE_W     = TILE_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  cu_seq_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(QK_LEN, SV_LEN);

  cu_state_e         state, state_n;
  logic [TILE_W-1:0] tile_idx, tiles_left;
  logic              mult_clear;
  logic              beat_en, at_last_c, last_c, lead_c;
  logic              qk_last_c, sv_last_c, start_ok;
  logic [CNT_W-1:0]  last_val;

  assign start_ok  = (state == IDLE) & bus.i_start;
  assign beat_en   = ((state == Q_K) & bus.i_qk_valid) | ((state == S_V) & bus.i_v_valid);
  assign last_val  = (state == S_V) ? CNT_W'(SV_LEN - 1) : CNT_W'(QK_LEN - 1);
  assign qk_last_c = (state == Q_K) & last_c;
  assign sv_last_c = (state == S_V) & last_c;

  cu_beat_cnt #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.i_abort),
    .en        (beat_en),
    .last_val  (last_val),
    .lead_val  (CNT_W'(SV_LEN - 1 - V_REQ_LEAD)),
    .at_last_c (at_last_c),
    .last_c    (last_c),
    .lead_c    (lead_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and zero-latency strobes.
  always_comb begin
    state_n                = state;
    bus.o_qk_ready         = (state == Q_K);
    bus.o_v_ready          = (state == S_V);
    bus.o_accu_en          = (state == Q_K) & bus.i_qk_valid;
    bus.o_qk_part_last     = qk_last_c;
    bus.o_mult_en          = (state == S_V) & bus.i_v_valid;
    bus.o_reduction_en     = (state == EXP) | ((state == S_V) & ~at_last_c);
    bus.o_v_data_request   = (state == S_V) & lead_c;
    bus.o_busy             = (state != IDLE);
    bus.o_done             = (state == DONE);
    case (state)
      IDLE:    if (bus.i_start) state_n = (bus.i_num_tiles != '0) ? Q_K : DONE;
      Q_K:     if (qk_last_c) state_n = EXP;
      EXP:     if (bus.i_exp_valid) state_n = S_V;
      S_V:     if (sv_last_c) state_n = (tiles_left == TILE_W'(1)) ? DONE : Q_K;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.i_abort) state_n = IDLE;
  end

  // Tile bookkeeping and the one-cycle-late multiplier clear.
  always_ff @(posedge clk) begin
    if (rst || bus.i_abort) begin
      tile_idx   <= '0;
      tiles_left <= '0;
      mult_clear <= 1'b0;
    end else begin
      mult_clear <= sv_last_c;
      if (start_ok) tiles_left <= bus.i_num_tiles;
      if (sv_last_c) begin
        tile_idx   <= tile_idx + TILE_W'(1);
        tiles_left <= tiles_left - TILE_W'(1);
      end
      if (state == DONE) tile_idx <= '0;
    end
  end

  assign bus.o_tile_idx   = tile_idx;
  assign bus.o_mult_clear = mult_clear;

`ifdef CU_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles, exp_wait_cycles;
  logic        stall_c;

  assign stall_c = ((state == Q_K) & ~bus.i_qk_valid) | ((state == S_V) & ~bus.i_v_valid);

  // Saturating counters, restarted with each accepted job.
  always_ff @(posedge clk) begin
    if (rst || bus.i_abort || start_ok) begin
      stall_cycles    <= '0;
      exp_wait_cycles <= '0;
    end else begin
      if (stall_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'(1);
      if ((state == EXP) && (exp_wait_cycles != '1))
        exp_wait_cycles <= exp_wait_cycles + 32'(1);
    end
  end

  assign bus.o_stall_cycles    = stall_cycles;
  assign bus.o_exp_wait_cycles = exp_wait_cycles;
`endif

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
- Parametrised attention compute-unit sequencer; next generation of the fixed-length CU controller.
- Drives the PE array, fan controller and V-fetch logic through multi-tile Q·Kᵀ → exp → S·V passes.
- Adds programmable tile count, stall-on-invalid beats, configurable phase lengths, configurable V-request lead, abort and a done handshake.
- Sits between the tile scheduler and the pe_array / fan_ctrl pair.

Parameters:
- QK_LEN, 65: beats per Q_K phase (counter 0..QK_LEN-1).
- SV_LEN, 65: beats per S_V phase.
- V_REQ_LEAD, 1: cycles before the S_V last beat at which o_v_data_request pulses; range 1..SV_LEN-1.
- TILE_W, 8: width of tile-count input.
- CNT_W, $clog2(max(QK_LEN,SV_LEN)): beat counter width, derived.

Ports:
- clk  in  1  clock; only clock domain.
- rst  in  1  reset; synchronous, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_num_tiles  in  TILE_W  tiles to process; latched on accepted i_start.
- i_abort  in  1  synchronous abort, any state.
- i_qk_valid  in  1  Q/K data and index beat valid.
- i_v_valid  in  1  V data beat valid.
- i_exp_valid  in  1  exp unit finished.
- o_qk_ready  out  1  high in Q_K state.
- o_v_ready  out  1  high in S_V state.
- o_accu_en  out  1  PE accumulate enable = Q_K & i_qk_valid.
- o_qk_part_last  out  1  last Q_K beat accepted.
- o_mult_en  out  1  = S_V & i_v_valid.
- o_mult_clear  out  1  registered S_V last beat (one cycle late).
- o_reduction_en  out  1  = EXP | (S_V & cnt < SV_LEN-1).
- o_v_data_request  out  1  one-cycle pulse, see Behaviour.
- o_tile_idx  out  TILE_W  current tile, 0-based.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse at end of run.

Behaviour:
- States: IDLE, Q_K, EXP, S_V, DONE. Reset: IDLE; cnt=0; tile_idx=0; all outputs 0.
- IDLE:
  - i_start & i_num_tiles!=0 → Q_K; latch tiles_left=i_num_tiles.
  - i_start & i_num_tiles==0 → DONE.
  - i_start is ignored outside IDLE.
- Q_K:
  - cnt increments only on i_qk_valid; an invalid cycle holds cnt (stall).
  - Last beat = cnt==QK_LEN-1 & i_qk_valid → o_qk_part_last=1 that cycle; cnt←0; → EXP.
- EXP: wait any number of cycles for i_exp_valid; then → S_V with cnt=0.
- S_V:
  - Same stall rule on i_v_valid.
  - o_v_data_request=1 when cnt==SV_LEN-1-V_REQ_LEAD & i_v_valid; pulses exactly once per tile, even under stall.
  - Last beat: cnt←0; tile_idx+1; tiles_left-1.
    - Remaining tiles >0 → Q_K.
    - Remaining tiles =0 → DONE.
- DONE: o_done=1 for one cycle → IDLE; tile_idx←0.
- o_mult_clear = registered (S_V last beat); it may therefore assert in the first cycle of the next Q_K or DONE.
- Combinational strobes (o_accu_en, o_mult_en, o_reduction_en, o_qk_part_last, readies) derive from the current state and counter; zero latency.
- i_abort (highest priority below rst):
  - Next state IDLE; cnt, tile_idx, tiles_left and o_mult_clear register cleared.
  - No o_done is generated.
  - Abort in the same cycle as a last beat still suppresses the state advance; the combinational last strobes for that cycle still fire.
- i_exp_valid outside EXP and i_qk_valid/i_v_valid outside their states are ignored.
- Reset mid-run behaves identically to abort, plus all outputs 0 the following cycle.
- tile_idx wraps never: its maximum is i_num_tiles-1 ≤ 2^TILE_W-2.

Optional Feature:
- Macro CU_SEQ_PERF_CNT_EN.
- With it defined:
  - Adds outputs o_stall_cycles[31:0] and o_exp_wait_cycles[31:0].
  - Counters: Q_K or S_V cycles with no valid beat; EXP cycles.
  - Both cleared on accepted i_start, rst or i_abort; saturate at 2^32-1.
- Without it: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package cu_pkg:
  - State enum and its encodings IDLE=3'd0, Q_K=3'd1, EXP=3'd2, S_V=3'd3, DONE=3'd4.
  - Default phase-length localparams.
- Sub-module cu_beat_cnt: stall-aware beat counter with parametrised limit and last/lead-tap outputs; instantiated once for Q_K and once for S_V, or once shared.

Test Plan:
- Nominal run:
  - Stimulus: QK_LEN=65, SV_LEN=65, V_REQ_LEAD=1, i_num_tiles=2; valids held high; i_exp_valid 3 cycles after EXP entry.
  - Response: o_qk_part_last pulses at beat 64 twice; o_v_data_request at cnt 63 twice; o_mult_clear one cycle after each S_V last; tile_idx 0→1; o_done single pulse; o_busy falls the cycle after.
- Stall:
  - Stimulus: deassert i_qk_valid for 5 cycles at cnt=10.
  - Response: cnt holds 10, o_accu_en=0 for those cycles, o_qk_part_last delayed by exactly 5 cycles.
- Zero tiles:
  - Stimulus: i_start with i_num_tiles=0.
  - Response: o_done the next cycle; no o_qk_ready ever.
- Abort:
  - Stimulus: i_abort at S_V cnt=30, tile 1 of 3.
  - Response: IDLE next cycle; o_done never; a fresh i_start restarts with tile_idx=0.
- Lead and stall:
  - Stimulus: V_REQ_LEAD=4; stall S_V at cnt=60 for 3 cycles.
  - Response: exactly one o_v_data_request pulse, on the valid beat at cnt=60.
- Reset mid-run:
  - Stimulus: rst during EXP.
  - Response: all outputs 0 next cycle; late i_exp_valid is ignored.
